// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - source/FIFO write-side bundle for the two-source burst arbiter
interface fifo_wr_arb_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  arb_en;
  logic                  src0_req;
  logic                  src1_req;
  logic                  src0_valid;
  logic                  src1_valid;
  logic [DATA_WIDTH-1:0] src0_data;
  logic [DATA_WIDTH-1:0] src1_data;
  logic                  src0_ready;
  logic                  src1_ready;
  logic                  src0_done;
  logic                  src1_done;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_wr_vld;
  logic                  busy;
  logic                  gnt_id;

  modport slave (
    input  arb_en, src0_req, src1_req, src0_valid, src1_valid,
    input  src0_data, src1_data, fifo_wr_vld,
    output src0_ready, src1_ready, src0_done, src1_done,
    output fifo_wr_en, fifo_wr_data, busy, gnt_id
  );

  modport master (
    output arb_en, src0_req, src1_req, src0_valid, src1_valid,
    output src0_data, src1_data, fifo_wr_vld,
    input  src0_ready, src1_ready, src0_done, src1_done,
    input  fifo_wr_en, fifo_wr_data, busy, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter feeding one FIFO write port
// A grant is locked for BURST_LEN beats; one IDLE cycle always separates bursts.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int BCNT_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fifo_wr_arb_if.slave bus
);
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [BCNT_WIDTH-1:0] BCNT_LAST = BCNT_WIDTH'(BURST_LEN - 1);

  state_t                state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  rr_q, rr_d;
  logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [1:0]            done_q, done_d;
  logic                  gnt_id_q, gnt_id_d;

  logic [1:0]            ready;
  logic [1:0]            beat;
  logic                  last_beat;
  logic                  any_req;
  logic                  winner;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    // Ready is masked during reset so a half-finished burst cannot push one more beat.
    ready     = rst ? 2'b00 : (gnt_q & {2{bus.fifo_wr_vld}});
    beat      = ready & {bus.src1_valid, bus.src0_valid};
    last_beat = (|beat) && (bcnt_q == BCNT_LAST);
    any_req   = bus.src0_req | bus.src1_req;
    winner    = (bus.src0_req && bus.src1_req) ? rr_q : bus.src1_req;

    wr_data = '0;
    if (gnt_q[0]) begin
      wr_data = bus.src0_data;
    end else if (gnt_q[1]) begin
      wr_data = bus.src1_data;
    end

    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    bcnt_d   = bcnt_q;
    done_d   = 2'b00;
    gnt_id_d = gnt_id_q;

    case (state_q)
      IDLE: begin
        if (bus.arb_en && any_req) begin
          state_d  = BURST;
          gnt_d    = winner ? 2'b10 : 2'b01;
          gnt_id_d = winner;
          bcnt_d   = '0;
        end
      end
      BURST: begin
        if (|beat) begin
          bcnt_d = bcnt_q + 1'b1;
          if (last_beat) begin
            // The loser of this burst gets priority next time.
            state_d = IDLE;
            gnt_d   = 2'b00;
            bcnt_d  = '0;
            done_d  = gnt_q;
            rr_d    = ~gnt_id_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      rr_q     <= 1'b0;
      bcnt_q   <= '0;
      done_q   <= 2'b00;
      gnt_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      bcnt_q   <= bcnt_d;
      done_q   <= done_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign bus.src0_ready   = ready[0];
  assign bus.src1_ready   = ready[1];
  assign bus.src0_done    = done_q[0];
  assign bus.src1_done    = done_q[1];
  assign bus.fifo_wr_en   = |beat;
  assign bus.fifo_wr_data = wr_data;
  assign bus.busy         = (state_q == BURST);
  assign bus.gnt_id       = gnt_id_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - vector table plus scoreboarded burst sequences for fifo_wr_arb
module tb_fifo_wr_arb;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0000;
  localparam logic [63:0] B1 = 64'hB1B1_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.DATA_WIDTH(DW)) ifc();

  fifo_wr_arb #(.DATA_WIDTH(DW), .BURST_LEN(BL), .BCNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [31:0] seq0 = 32'd0;
  logic [31:0] seq1 = 32'd0;
  assign ifc.src0_data = A0 | {32'd0, seq0};
  assign ifc.src1_data = B1 | {32'd0, seq1};

  int nvec = 0;
  int nerr = 0;
  logic [63:0] sbq[$];

  typedef struct {
    logic busy, gnt_id, rdy0, rdy1, wen, done0, done1;
    logic [63:0] wdata;
  } snap_t;
  snap_t snap;

  typedef struct {
    logic rst, arb_en, req0, req1, val0, val1, vld;
    logic busy, gnt_id, rdy0, rdy1, wen, done0, done1;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic en, input logic q0, input logic q1,
                        input logic v0, input logic v1, input logic vld);
    rst            = r;
    ifc.arb_en     = en;
    ifc.src0_req   = q0;
    ifc.src1_req   = q1;
    ifc.src0_valid = v0;
    ifc.src1_valid = v1;
    ifc.fifo_wr_vld = vld;
  endtask

  task automatic push_exp(input logic k, input int start, input int n);
    for (int i = 0; i < n; i++) sbq.push_back((k ? B1 : A0) | 64'(start + i));
  endtask

  // Sample mid-cycle, score any write, then let the sources advance after the edge.
  task automatic step();
    logic b0, b1;
    @(negedge clk);
    snap.busy   = ifc.busy;
    snap.gnt_id = ifc.gnt_id;
    snap.rdy0   = ifc.src0_ready;
    snap.rdy1   = ifc.src1_ready;
    snap.wen    = ifc.fifo_wr_en;
    snap.done0  = ifc.src0_done;
    snap.done1  = ifc.src1_done;
    snap.wdata  = ifc.fifo_wr_data;
    b0 = ifc.src0_valid & ifc.src0_ready;
    b1 = ifc.src1_valid & ifc.src1_ready;
    if (snap.wen === 1'b1) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_unexpected_write: got %0h expected no write", snap.wdata);
      end else begin
        chk("wr_data", snap.wdata, sbq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (b0 === 1'b1) seq0 = seq0 + 1;
    if (b1 === 1'b1) seq1 = seq1 + 1;
  endtask

  task automatic burst(input logic k, input logic stall);
    int nb, nbusy, st;
    logic got, v;
    nb = 0; nbusy = 0; st = 0; got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      v = 1'b1;
      if (stall && nb == 5 && st < 3) begin
        v = 1'b0;
        st++;
      end
      if (stall && !k) ifc.src1_req = (nb >= 8);
      if (k) ifc.src1_valid = v; else ifc.src0_valid = v;
      step();
      if (c == 0) begin
        chk("grant_latency", 64'(snap.busy), 64'd1);
        chk("grant_id", 64'(snap.gnt_id), 64'(k));
      end
      if (snap.busy) nbusy++;
      if (snap.wen === 1'b1) nb++;
      chk("other_ready", 64'(k ? snap.rdy0 : snap.rdy1), 64'd0);
      chk("other_done", 64'(k ? snap.done0 : snap.done1), 64'd0);
      got = k ? snap.done1 : snap.done0;
    end
    chk("done_pulse", 64'(got), 64'd1);
    chk("beats_per_burst", 64'(nb), 64'(BL));
    chk("busy_cycles", 64'(nbusy), 64'(BL + (stall ? 3 : 0)));
    chk("busy_at_done", 64'(snap.busy), 64'd0);
  endtask

  initial begin
    int nb;
    logic got, vld;

    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step();

    //          rst en q0 q1 v0 v1 vld  busy gid r0 r1 wen d0 d1
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    push_exp(1'b0, 0, BL);
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i].rst, vt[i].arb_en, vt[i].req0, vt[i].req1, vt[i].val0, vt[i].val1, vt[i].vld);
      step();
      chk($sformatf("vec%0d.busy", i),   64'(snap.busy),   64'(vt[i].busy));
      chk($sformatf("vec%0d.gnt_id", i), 64'(snap.gnt_id), 64'(vt[i].gnt_id));
      chk($sformatf("vec%0d.rdy0", i),   64'(snap.rdy0),   64'(vt[i].rdy0));
      chk($sformatf("vec%0d.rdy1", i),   64'(snap.rdy1),   64'(vt[i].rdy1));
      chk($sformatf("vec%0d.wen", i),    64'(snap.wen),    64'(vt[i].wen));
      chk($sformatf("vec%0d.done0", i),  64'(snap.done0),  64'(vt[i].done0));
      chk($sformatf("vec%0d.done1", i),  64'(snap.done1),  64'(vt[i].done1));
      if (i == 2) chk("idle_wr_data_zero", snap.wdata, 64'd0);
    end

    // Finish the src0 burst with the FIFO ready toggling every cycle.
    nb = 3; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      vld = (c % 2 == 1);
      set_in(0, 0, 0, 1, 1, 1, vld);
      step();
      got = snap.done0;
      if (!got) begin
        chk("toggle_ready_mirrors_vld", 64'(snap.rdy0), 64'(vld));
        chk("toggle_wen_mirrors_vld", 64'(snap.wen), 64'(vld));
        chk("toggle_busy", 64'(snap.busy), 64'd1);
        if (snap.wen === 1'b1) nb++;
      end
    end
    chk("toggle_done_pulse", 64'(got), 64'd1);
    chk("toggle_beats", 64'(nb), 64'(BL));
    chk("toggle_busy_at_done", 64'(snap.busy), 64'd0);
    chk("toggle_gnt_id_held", 64'(snap.gnt_id), 64'd0);

    set_in(0, 1, 1, 1, 1, 1, 1);
    step();
    chk("arb_en_low_blocked_grant", 64'(snap.busy), 64'd0);
    chk("ungranted_wr_data_zero", snap.wdata, 64'd0);

    push_exp(1'b1, 0, BL);
    push_exp(1'b0, 16, BL);
    push_exp(1'b1, 16, BL);
    burst(1'b1, 1'b0);
    burst(1'b0, 1'b0);
    burst(1'b1, 1'b0);

    push_exp(1'b0, 32, BL);
    burst(1'b0, 1'b1);

    // src1 is granted next; abandon it with reset after its eighth beat.
    push_exp(1'b1, 32, 8);
    nb = 0;
    for (int c = 0; c < 40 && nb < 8; c++) begin
      step();
      if (c == 0) chk("rst_test_grant_src1", 64'(snap.gnt_id), 64'd1);
      if (snap.wen === 1'b1) nb++;
    end
    chk("rst_test_beats_before_rst", 64'(nb), 64'd8);
    rst = 1'b1;
    step();
    chk("rst_cycle_ready1", 64'(snap.rdy1), 64'd0);
    chk("rst_cycle_wen", 64'(snap.wen), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_busy", 64'(snap.busy), 64'd0);
    chk("post_rst_gnt_id", 64'(snap.gnt_id), 64'd0);
    chk("post_rst_no_done1", 64'(snap.done1), 64'd0);
    chk("post_rst_no_done0", 64'(snap.done0), 64'd0);
    chk("post_rst_wen", 64'(snap.wen), 64'd0);

    push_exp(1'b0, 48, BL);
    burst(1'b0, 1'b0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
